// File: rtl/pc_cycle_sequencer.sv
// pc_cycle_sequencer
//
// Owns the program counter. Steps each instruction through fetch, decode,
// execute and PC update, and retires one instruction per completed cycle.
// Each stage gets a one-cycle start pulse. The sequencer then waits for that
// stage's done handshake. In UPDATE it commits the next program number
// (sequential, branch or jump) and bumps the saturating retired counter.
//
// Build option:
//   NPI_TRAP_EN  when defined, illegal control (2'b11) loads TRAP_VECTOR.
//                When undefined, illegal control loads programCount + 1.
//                In both builds illegal control sets the sticky errorFlag.
//
// Parameters:
//   SIZE         program counter width
//   RESET_PC     program counter value after reset
//   TRAP_VECTOR  illegal-control target (NPI_TRAP_EN builds only)
//
// Ports:
//   clock, reset                       clock; async active-high reset
//   start                              leave IDLE
//   fetchDone/decodeDone/executeDone   stage completion handshakes
//   halt                               decoded halt, qualified by decodeDone
//   nextProgramControl                 00 seq, 01 branch, 10 jump, 11 illegal
//   branchResult/jumpResult            candidate targets, sampled in UPDATE
//   programCount                       current program number
//   fetchStart/decodeStart/executeStart one-cycle stage start pulses
//   cycleDone                          one-cycle pulse in UPDATE
//   busy, halted                       status flags
//   errorFlag                          sticky illegal-control flag
//   retiredCount                       saturating retired-instruction count
//
// All outputs are registered. The next-cycle value of each output is
// computed from the next state.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for start
// FETCH   | fetch issued, waiting for fetchDone
// DECODE  | decode issued, waiting for decodeDone
// EXECUTE | execute issued, waiting for executeDone
// UPDATE  | one cycle: commit next PC, retire instruction
// HALT    | halt decoded; only reset leaves

module pc_cycle_sequencer #(
    parameter int              SIZE        = 8,
    parameter logic [SIZE-1:0] RESET_PC    = '0,
    parameter logic [SIZE-1:0] TRAP_VECTOR = {SIZE{1'b1}}
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            fetchDone,
    input  logic            decodeDone,
    input  logic            executeDone,
    input  logic            halt,
    input  logic [1:0]      nextProgramControl,
    input  logic [SIZE-1:0] branchResult,
    input  logic [SIZE-1:0] jumpResult,
    output logic [SIZE-1:0] programCount,
    output logic            fetchStart,
    output logic            decodeStart,
    output logic            executeStart,
    output logic            cycleDone,
    output logic            busy,
    output logic            halted,
    output logic            errorFlag,
    output logic [15:0]     retiredCount
);

`ifdef NPI_TRAP_EN
    localparam bit ILLEGAL_TRAPS = 1'b1;
`else
    localparam bit ILLEGAL_TRAPS = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_UPDATE, S_HALT
    } state_t;

    state_t          state, state_nx;
    logic            fetch_start_nx, decode_start_nx, execute_start_nx;
    logic            cycle_done_nx, busy_nx, halted_nx;
    logic [SIZE-1:0] pc_inc, pc_sel;

    always_comb begin
        state_nx = state;
        // A start pulse is high exactly in a stage's entry cycle.
        // A done that arrives in that cycle is therefore ignored.
        case (state)
            S_IDLE:    if (start) state_nx = S_FETCH;
            S_FETCH:   if (fetchDone && !fetchStart) state_nx = S_DECODE;
            S_DECODE:  if (decodeDone && !decodeStart)
                           state_nx = halt ? S_HALT : S_EXECUTE;
            S_EXECUTE: if (executeDone && !executeStart) state_nx = S_UPDATE;
            S_UPDATE:  state_nx = S_FETCH;
            S_HALT:    state_nx = S_HALT;
            default:   state_nx = S_IDLE;
        endcase

        fetch_start_nx   = (state_nx == S_FETCH)   && (state != S_FETCH);
        decode_start_nx  = (state_nx == S_DECODE)  && (state != S_DECODE);
        execute_start_nx = (state_nx == S_EXECUTE) && (state != S_EXECUTE);
        cycle_done_nx    = (state_nx == S_UPDATE);
        busy_nx          = (state_nx == S_FETCH) || (state_nx == S_DECODE) ||
                           (state_nx == S_EXECUTE) || (state_nx == S_UPDATE);
        halted_nx        = (state_nx == S_HALT);

        pc_inc = programCount + 1'b1;
        case (nextProgramControl)
            2'b01:   pc_sel = branchResult;
            2'b10:   pc_sel = jumpResult;
            2'b11:   pc_sel = ILLEGAL_TRAPS ? TRAP_VECTOR : pc_inc;
            default: pc_sel = pc_inc;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            programCount <= RESET_PC;
            fetchStart   <= 1'b0;
            decodeStart  <= 1'b0;
            executeStart <= 1'b0;
            cycleDone    <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            errorFlag    <= 1'b0;
            retiredCount <= 16'h0000;
        end else begin
            state        <= state_nx;
            fetchStart   <= fetch_start_nx;
            decodeStart  <= decode_start_nx;
            executeStart <= execute_start_nx;
            cycleDone    <= cycle_done_nx;
            busy         <= busy_nx;
            halted       <= halted_nx;
            if (state == S_UPDATE) begin
                programCount <= pc_sel;
                if (retiredCount != 16'hFFFF)
                    retiredCount <= retiredCount + 16'd1;
                if (nextProgramControl == 2'b11)
                    errorFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_cycle_sequencer.sv
// Testbench for pc_cycle_sequencer.
// A second instance with RESET_PC = 8'hFF shares all inputs. It is used to
// observe the wrap from all-ones to zero.
module tb_pc_cycle_sequencer;

    logic       clock = 1'b0;
    logic       reset, start, fetchDone, decodeDone, executeDone, halt;
    logic [1:0] nextProgramControl;
    logic [7:0] branchResult, jumpResult;

    logic [7:0]  programCount, programCount_b;
    logic        fetchStart, decodeStart, executeStart, cycleDone, busy, halted, errorFlag;
    logic        fetchStart_b, decodeStart_b, executeStart_b, cycleDone_b, busy_b, halted_b, errorFlag_b;
    logic [15:0] retiredCount, retiredCount_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference state: program number, retired count, sticky error.
    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    logic        m_err;

    pc_cycle_sequencer #(.SIZE(8), .RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset), .start(start),
        .fetchDone(fetchDone), .decodeDone(decodeDone), .executeDone(executeDone),
        .halt(halt), .nextProgramControl(nextProgramControl),
        .branchResult(branchResult), .jumpResult(jumpResult),
        .programCount(programCount), .fetchStart(fetchStart),
        .decodeStart(decodeStart), .executeStart(executeStart),
        .cycleDone(cycleDone), .busy(busy), .halted(halted),
        .errorFlag(errorFlag), .retiredCount(retiredCount)
    );

    pc_cycle_sequencer #(.SIZE(8), .RESET_PC(8'hFF)) dut_b (
        .clock(clock), .reset(reset), .start(start),
        .fetchDone(fetchDone), .decodeDone(decodeDone), .executeDone(executeDone),
        .halt(halt), .nextProgramControl(nextProgramControl),
        .branchResult(branchResult), .jumpResult(jumpResult),
        .programCount(programCount_b), .fetchStart(fetchStart_b),
        .decodeStart(decodeStart_b), .executeStart(executeStart_b),
        .cycleDone(cycleDone_b), .busy(busy_b), .halted(halted_b),
        .errorFlag(errorFlag_b), .retiredCount(retiredCount_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        start = 1'b0; fetchDone = 1'b0; decodeDone = 1'b0; executeDone = 1'b0;
        halt = 1'b0; nextProgramControl = 2'b00;
        branchResult = 8'h00; jumpResult = 8'h00;
    endtask

    task automatic set_done(input int s, input logic v);
        case (s)
            0:       fetchDone = v;
            1:       decodeDone = v;
            default: executeDone = v;
        endcase
    endtask

    // Drive every input the current stage must ignore. Stage 3 is UPDATE,
    // where all three dones are ignored.
    task automatic junk_others(input int s, input bit quiet);
        if (quiet) begin
            clear_inputs();
        end else begin
            start = 1'($urandom_range(0, 1));
            halt = 1'($urandom_range(0, 1));
            nextProgramControl = 2'($urandom_range(0, 3));
            branchResult = 8'($urandom);
            jumpResult = 8'($urandom);
            fetchDone = (s != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            decodeDone = (s != 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            executeDone = (s != 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic begin_run();
        clear_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in the entry cycle of stage s. Returns in the entry cycle of the
    // following state.
    task automatic do_stage(input int s, input bit fast, input bit hlt);
        logic pulse;
        int n;
        pulse = (s == 0) ? fetchStart : (s == 1) ? decodeStart : executeStart;
        checks++;
        if (pulse !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stage%0d_entry start=%b busy=%b required 1 1", s, pulse, busy);
        end
        checks++;
        if (programCount !== m_pc) begin
            errors++;
            $display("FAIL stage%0d_pc got %h required %h", s, programCount, m_pc);
        end
        // A done coincident with the start pulse must be ignored.
        junk_others(s, fast);
        set_done(s, fast ? 1'b0 : 1'($urandom_range(0, 1)));
        tick();
        n = fast ? 0 : int'($urandom_range(0, 3));
        for (int i = 0; i <= n; i++) begin
            checks++;
            if ({fetchStart, decodeStart, executeStart, cycleDone} !== 4'b0000 ||
                busy !== 1'b1 || programCount !== m_pc) begin
                errors++;
                $display("FAIL stage%0d_wait pulses=%b busy=%b pc=%h required 0000 1 %h",
                         s, {fetchStart, decodeStart, executeStart, cycleDone}, busy,
                         programCount, m_pc);
            end
            junk_others(s, (i == n) ? fast : 1'b0);
            set_done(s, (i == n) ? 1'b1 : 1'b0);
            if (s == 1 && i == n) halt = hlt;
            tick();
        end
        clear_inputs();
    endtask

    task automatic run_instr(input logic [1:0] ctrl, input logic [7:0] br,
                             input logic [7:0] jr, input bit fast, output int done_at);
        logic [7:0] exp_pc;
        do_stage(0, fast, 1'b0);
        do_stage(1, fast, 1'b0);
        do_stage(2, fast, 1'b0);
        checks++;
        if (cycleDone !== 1'b1 || busy !== 1'b1 || programCount !== m_pc ||
            retiredCount !== m_ret) begin
            errors++;
            $display("FAIL update_cycle done=%b busy=%b pc=%h ret=%h required 1 1 %h %h",
                     cycleDone, busy, programCount, retiredCount, m_pc, m_ret);
        end
        done_at = cyc;
        junk_others(3, fast);
        nextProgramControl = ctrl;
        branchResult = br;
        jumpResult = jr;
        tick();
        clear_inputs();
        case (ctrl)
            2'b00: exp_pc = m_pc + 8'd1;
            2'b01: exp_pc = br;
            2'b10: exp_pc = jr;
            default: begin
`ifdef NPI_TRAP_EN
                exp_pc = 8'hFF;
`else
                exp_pc = m_pc + 8'd1;
`endif
                m_err = 1'b1;
            end
        endcase
        m_pc = exp_pc;
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        checks++;
        if (programCount !== m_pc) begin
            errors++;
            $display("FAIL next_pc ctrl=%b got %h required %h", ctrl, programCount, m_pc);
        end
        checks++;
        if (retiredCount !== m_ret || errorFlag !== m_err || cycleDone !== 1'b0) begin
            errors++;
            $display("FAIL retire ret=%h err=%b done=%b required %h %b 0",
                     retiredCount, errorFlag, cycleDone, m_ret, m_err);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (programCount !== 8'h00 || retiredCount !== 16'h0 ||
            {fetchStart, decodeStart, executeStart, cycleDone, busy, halted, errorFlag} !== 7'b0) begin
            errors++;
            $display("FAIL reset_values pc=%h ret=%h flags=%b required 00 0000 0000000", programCount,
                     retiredCount, {fetchStart, decodeStart, executeStart, cycleDone, busy, halted, errorFlag});
        end
        checks++;
        if (programCount_b !== 8'hFF) begin
            errors++;
            $display("FAIL reset_pc_b got %h required ff", programCount_b);
        end
        reset = 1'b0;
        fetchDone = 1'b1; decodeDone = 1'b1; executeDone = 1'b1;
        tick(); tick();
        clear_inputs();
        checks++;
        if (busy !== 1'b0 || fetchStart !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start busy=%b fetchStart=%b required 0 0", busy, fetchStart);
        end
        m_pc = 8'h00; m_ret = 16'h0; m_err = 1'b0;
    endtask

    task automatic test_sequential();
        int c0, d;
        begin_run();
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            run_instr(2'b00, 8'($urandom), 8'($urandom), 1'b1, d);
            checks++;
            if (d - c0 !== 6 + 7 * k) begin
                errors++;
                $display("FAIL cycle_done_time instr%0d got c%0d required c%0d", k, d - c0, 6 + 7 * k);
            end
            if (k == 0) begin
                checks++;
                if (programCount_b !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_ff got %h required 00", programCount_b);
                end
            end
        end
        checks++;
        if (programCount !== 8'h03 || retiredCount !== 16'd3) begin
            errors++;
            $display("FAIL seq_three pc=%h ret=%0d required 03 3", programCount, retiredCount);
        end
    endtask

    task automatic test_branch_jump();
        int d;
        run_instr(2'b10, 8'($urandom), 8'h05, 1'b0, d);
        run_instr(2'b01, 8'h40, 8'($urandom), 1'b0, d);
        checks++;
        if (programCount !== 8'h40) begin
            errors++;
            $display("FAIL branch got %h required 40", programCount);
        end
        run_instr(2'b10, 8'($urandom), 8'h10, 1'b0, d);
        checks++;
        if (programCount !== 8'h10) begin
            errors++;
            $display("FAIL jump got %h required 10", programCount);
        end
    endtask

    task automatic test_illegal();
        int d;
        run_instr(2'b10, 8'h00, 8'h07, 1'b1, d);
        run_instr(2'b11, 8'h55, 8'hAA, 1'b1, d);
        run_instr(2'b00, 8'h55, 8'hAA, 1'b0, d);
        checks++;
        if (errorFlag !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky got %b required 1", errorFlag);
        end
    endtask

    task automatic test_random();
        int d;
        for (int k = 0; k < 25; k++)
            run_instr(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 1)), d);
    endtask

    task automatic test_reset_mid_execute();
        do_stage(0, 1'b0, 1'b0);
        do_stage(1, 1'b0, 1'b0);
        checks++;
        if (executeStart !== 1'b1) begin
            errors++;
            $display("FAIL exec_entry got %b required 1", executeStart);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (programCount !== 8'h00 || retiredCount !== 16'h0 ||
            {fetchStart, decodeStart, executeStart, cycleDone, busy, halted, errorFlag} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset pc=%h ret=%h flags=%b required 00 0000 0000000", programCount,
                     retiredCount, {fetchStart, decodeStart, executeStart, cycleDone, busy, halted, errorFlag});
        end
        executeDone = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || cycleDone !== 1'b0 || programCount !== 8'h00 || retiredCount !== 16'h0) begin
            errors++;
            $display("FAIL stale_done busy=%b done=%b pc=%h ret=%h required 0 0 00 0000",
                     busy, cycleDone, programCount, retiredCount);
        end
        m_pc = 8'h00; m_ret = 16'h0; m_err = 1'b0;
        begin
            int d;
            begin_run();
            run_instr(2'b00, 8'h00, 8'h00, 1'b0, d);
        end
    endtask

    task automatic test_halt();
        int d;
        run_instr(2'b10, 8'h00, 8'h03, 1'b0, d);
        do_stage(0, 1'b0, 1'b0);
        do_stage(1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (halted !== 1'b1 || busy !== 1'b0 || programCount !== 8'h03 ||
                retiredCount !== m_ret ||
                {fetchStart, decodeStart, executeStart, cycleDone} !== 4'b0000) begin
                errors++;
                $display("FAIL halt_hold%0d halted=%b busy=%b pc=%h ret=%h required 1 0 03 %h",
                         k, halted, busy, programCount, retiredCount, m_ret);
            end
            junk_others(3, 1'b0);
            start = 1'b1;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        test_reset();
        test_sequential();
        test_branch_jump();
        test_illegal();
        test_random();
        test_reset_mid_execute();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_cycle_sequencer.md
# pc_cycle_sequencer

Multi-cycle instruction sequencer that owns the program counter and drives the fetch → decode → execute → PC-update cycle of the processor. It issues one-cycle start pulses to each stage, waits for the stage's done handshake, then selects the next program number (sequential, branch or jump) and commits it. It replaces the free-running done/reset sequencing around next-program selection with a single clocked FSM, and adds halt, error and retired-instruction counting.

## Interface
- SIZE, 8, program-counter width in bits
- RESET_PC, 0, program counter value after reset
- TRAP_VECTOR, {SIZE{1'b1}}, trap target; used only with `NPI_TRAP_EN`
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  leaves IDLE; ignored in every other state
- fetchDone / decodeDone / executeDone  in  1 each  stage completion handshakes
- halt  in  1  decoded halt instruction; sampled only together with decodeDone
- nextProgramControl  in  2  00 sequential, 01 branch, 10 jump, 11 illegal
- branchResult / jumpResult  in  SIZE each  candidate targets, sampled in UPDATE
- programCount  out  SIZE  current program number
- fetchStart / decodeStart / executeStart  out  1 each  one-cycle stage start pulses
- cycleDone  out  1  one-cycle pulse when the PC is committed
- busy  out  1  high in FETCH, DECODE, EXECUTE and UPDATE
- halted  out  1  high in HALT
- errorFlag  out  1  sticky; set by illegal control
- retiredCount  out  16  instructions retired; saturates at 16'hFFFF

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, UPDATE, HALT.
- Reset values: state IDLE, programCount = RESET_PC, retiredCount = 0, every other output = 0.
- IDLE → FETCH when start = 1.
- FETCH: fetchStart = 1 in the entry cycle only. → DECODE on fetchDone.
- DECODE: decodeStart = 1 in the entry cycle only.
  - decodeDone with halt = 1 → HALT.
  - decodeDone with halt = 0 → EXECUTE.
- EXECUTE: executeStart = 1 in the entry cycle only. → UPDATE on executeDone.
- UPDATE: lasts exactly one cycle; cycleDone = 1; then → FETCH. On the exiting edge:
  - programCount ← selected next value.
  - retiredCount ← retiredCount + 1, saturating.
- Next-value selection:
  - 00: programCount + 1, truncated to SIZE bits, so all-ones wraps to 0.
  - 01: branchResult.
  - 10: jumpResult.
  - 11: programCount + 1, and errorFlag ← 1.
- HALT: absorbing state; programCount and retiredCount hold. The halt instruction is not retired. Only reset exits HALT.
- Done inputs are accepted only in their own state and only from the cycle after that state's start pulse. A done in any other state or cycle is ignored. This includes a done coincident with its own start pulse.
- Simultaneous done inputs: only the one belonging to the current state has effect.
- Reset asserted mid-operation:
  - All outputs are forced to reset values asynchronously, including any start pulse in flight.
  - The pending stage result is discarded.
  - After reset deasserts, the block waits in IDLE for start.

## Timing
- Minimum instruction latency is 7 cycles, with each done arriving the cycle after its start:
  - c0: FETCH entry, fetchStart.
  - c1: fetchDone.
  - c2: decodeStart.
  - c3: decodeDone.
  - c4: executeStart.
  - c5: executeDone.
  - c6: UPDATE, cycleDone.
  - c7: FETCH, with the new programCount visible.
- Each stage may stall indefinitely; there is no timeout.
- programCount changes only on the clock edge leaving UPDATE. It is stable for the entire FETCH through EXECUTE window.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `NPI_TRAP_EN` defined: control 11 loads programCount ← TRAP_VECTOR and sets errorFlag. The instruction still retires.
- `NPI_TRAP_EN` undefined: control 11 loads programCount + 1 and sets errorFlag. TRAP_VECTOR is unused.

## Test plan
- Reset, start, three instructions with control 00 and single-cycle-delayed dones → programCount goes 0, 1, 2, 3; retiredCount = 3; cycleDone pulses at c6, c13, c20.
- programCount = 5, control 01 with branchResult = 8'h40, then control 10 with jumpResult = 8'h10 → programCount 8'h40, then 8'h10.
- RESET_PC = 8'hFF, one instruction with control 00 → programCount wraps to 8'h00.
- Control 11 at programCount = 7 → errorFlag = 1 and stays 1. Next programCount is 8 without `NPI_TRAP_EN`, 8'hFF with it.
- decodeDone with halt = 1 at programCount = 3 → halted = 1, busy = 0, programCount stays 3, retiredCount unchanged; extra dones and start are ignored.
- Reset asserted while in EXECUTE with executeStart high → all outputs return to reset values within the same cycle, and a stale executeDone after reset has no effect.
